// File: rtl/cache_level_pkg.sv
// Shared opcodes, policy encodings and controller state for cache_level.
package cache_level_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  typedef enum logic {
    WP_WT = 1'b0,
    WP_WB = 1'b1
  } wpol_t;

  typedef enum logic {
    RP_FIFO = 1'b0,
    RP_LRU  = 1'b1
  } rpol_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_WB_REQ,
    S_FILL_REQ,
    S_WT_REQ
  } state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/cache_level_if.sv
// Request/response bus of one cache level: upper-side request channel plus
// the next-level request channel. master = environment, slave = cache.
interface cache_level_if #(
  parameter int ADDR_W = 48
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_op;
  logic              rsp_valid;
  logic              rsp_hit;
  logic              nl_valid;
  logic              nl_ready;
  logic [ADDR_W-1:0] nl_addr;
  logic [7:0]        nl_op;

  modport master (
    output req_valid, req_addr, req_op, nl_ready,
    input  req_ready, rsp_valid, rsp_hit, nl_valid, nl_addr, nl_op
  );

  modport slave (
    input  req_valid, req_addr, req_op, nl_ready,
    output req_ready, rsp_valid, rsp_hit, nl_valid, nl_addr, nl_op
  );
endinterface

// File: rtl/cache_level_repl.sv
// Replacement state: per-set FIFO pointer and per-way LRU ages, victim select.
module cache_level_repl
  import cache_level_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int ASSOC    = 4,
  parameter int IDX_W    = 6,
  parameter int WAY_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_set,
  input  logic [ASSOC-1:0] i_valid,
  input  rpol_t            i_policy,
  input  logic             i_touch,
  input  logic             i_fill,
  input  logic [WAY_W-1:0] i_way,
  input  logic             i_way_valid,
  output logic [WAY_W-1:0] o_victim
);

  logic [WAY_W-1:0] r_ptr [NUM_SETS];
  logic [WAY_W-1:0] r_age [NUM_SETS][ASSOC];

  logic             w_found_inv;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_old_way;
  logic [WAY_W-1:0] w_old_age;
  logic [WAY_W-1:0] w_touch_age;

  // Victim: lowest invalid way, else FIFO pointer or oldest age (ties -> lowest index).
  always_comb begin
    w_found_inv = 1'b0;
    w_inv_way   = '0;
    w_old_way   = '0;
    w_old_age   = '0;
    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (!i_valid[w] && !w_found_inv) begin
        w_found_inv = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
      if (r_age[i_set][w] > w_old_age) begin
        w_old_age = r_age[i_set][w];
        w_old_way = WAY_W'(w);
      end
    end
    if (w_found_inv)              o_victim = w_inv_way;
    else if (i_policy == RP_LRU)  o_victim = w_old_way;
    else                          o_victim = r_ptr[i_set];
  end

  // An invalid way being filled is treated as the oldest, so every other way
  // ages by one; this keeps valid-way ages a strict recency order from reset.
  always_comb begin
    w_touch_age = i_way_valid ? r_age[i_set][i_way] : WAY_W'(ASSOC - 1);
  end

  // Age/pointer update on hit (touch) or fill; pointer moves on fills only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_ptr[s] <= '0;
        for (int unsigned w = 0; w < ASSOC; w++) r_age[s][w] <= '0;
      end
    end else begin
      if (i_touch || i_fill) begin
        for (int unsigned w = 0; w < ASSOC; w++) begin
          if (WAY_W'(w) == i_way)              r_age[i_set][w] <= '0;
          else if (r_age[i_set][w] < w_touch_age) r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
        end
      end
      if (i_fill) begin
        r_ptr[i_set] <= (r_ptr[i_set] == WAY_W'(ASSOC - 1)) ? '0 : r_ptr[i_set] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_level.sv
// Single cache level: tag/valid/dirty store, lookup controller, next-level
// fill/write-back/write-through requests and saturating statistics.
module cache_level
  import cache_level_pkg::*;
#(
  parameter int ADDR_W      = 48,
  parameter int NUM_SETS    = 64,
  parameter int ASSOC       = 4,
  parameter int BLOCK_BYTES = 64,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_policy,
  input  logic             replace_policy,
  cache_level_if.slave     bus,
  output logic [CNT_W-1:0] reads,
  output logic [CNT_W-1:0] writes,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] misses,
  output logic [CNT_W-1:0] writebacks
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t                r_state;
  logic [ADDR_W-OFF_W-1:0] r_blk;
  logic [7:0]            r_op;
  wpol_t                 r_wp;
  rpol_t                 r_rp;
  logic                  r_hit;
  logic [WAY_W-1:0]      r_victim;
  logic                  r_req_ready, r_rsp_valid, r_rsp_hit, r_nl_valid;
  logic [ADDR_W-1:0]     r_nl_addr;
  logic [7:0]            r_nl_op;
  logic [CNT_W-1:0]      r_reads, r_writes, r_hits, r_misses, r_wbs;

  logic [TAG_W-1:0]      r_tag   [NUM_SETS][ASSOC];
  logic [ASSOC-1:0]      r_valid [NUM_SETS];
  logic [ASSOC-1:0]      r_dirty [NUM_SETS];

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [ADDR_W-1:0]     w_aligned;
  logic                  w_is_write;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_victim_dirty;
  logic [ADDR_W-1:0]     w_victim_addr;
  logic                  w_lookup_hit;
  logic                  w_fill_done;
  logic [WAY_W-1:0]      w_upd_way;

  assign w_idx          = r_blk[IDX_W-1:0];
  assign w_tag          = r_blk[ADDR_W-OFF_W-1:IDX_W];
  assign w_aligned      = {r_blk, {OFF_W{1'b0}}};
  assign w_is_write     = (r_op == OP_WRITE);
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  assign w_victim_addr  = {r_tag[w_idx][w_victim], w_idx, {OFF_W{1'b0}}};
  assign w_lookup_hit   = (r_state == S_LOOKUP) && w_hit;
  assign w_fill_done    = (r_state == S_FILL_REQ) && r_nl_valid && bus.nl_ready;
  assign w_upd_way      = w_lookup_hit ? w_hit_way : r_victim;

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_hit    = r_rsp_hit;
  assign bus.nl_valid   = r_nl_valid;
  assign bus.nl_addr    = r_nl_addr;
  assign bus.nl_op      = r_nl_op;
  assign reads          = r_reads;
  assign writes         = r_writes;
  assign hits           = r_hits;
  assign misses         = r_misses;
  assign writebacks     = r_wbs;

  // Tag compare across all ways of the latched set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  cache_level_repl #(
    .NUM_SETS (NUM_SETS),
    .ASSOC    (ASSOC),
    .IDX_W    (IDX_W),
    .WAY_W    (WAY_W)
  ) u_repl (
    .clk         (clk),
    .reset       (reset),
    .i_set       (w_idx),
    .i_valid     (r_valid[w_idx]),
    .i_policy    (r_rp),
    .i_touch     (w_lookup_hit),
    .i_fill      (w_fill_done),
    .i_way       (w_upd_way),
    .i_way_valid (r_valid[w_idx][w_upd_way]),
    .o_victim    (w_victim)
  );

  // Valid/dirty bits: set dirty on write-back write hit, install on fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      if (w_lookup_hit && w_is_write && (r_wp == WP_WB)) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_fill_done) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= w_is_write && (r_wp == WP_WB);
      end
    end
  end

  // Tag store is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_fill_done) r_tag[w_idx][r_victim] <= w_tag;
  end

  // Request controller with registered handshake outputs and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_blk       <= '0;
      r_op        <= '0;
      r_wp        <= WP_WT;
      r_rp        <= RP_FIFO;
      r_hit       <= 1'b0;
      r_victim    <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_nl_valid  <= 1'b0;
      r_nl_addr   <= '0;
      r_nl_op     <= '0;
      r_reads     <= '0;
      r_writes    <= '0;
      r_hits      <= '0;
      r_misses    <= '0;
      r_wbs       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_blk       <= bus.req_addr[ADDR_W-1:OFF_W];
            r_op        <= bus.req_op;
            r_wp        <= wpol_t'(write_policy);
            r_rp        <= rpol_t'(replace_policy);
            r_req_ready <= 1'b0;
            if (bus.req_op == OP_READ)  r_reads  <= sat_inc(r_reads);
            if (bus.req_op == OP_WRITE) r_writes <= sat_inc(r_writes);
            if (op_legal(bus.req_op)) begin
              r_state <= S_LOOKUP;
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_hit   <= 1'b0;
            end
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) begin
            r_hits <= sat_inc(r_hits);
            if (w_is_write && (r_wp == WP_WT)) begin
              r_state    <= S_WT_REQ;
              r_nl_valid <= 1'b1;
              r_nl_addr  <= w_aligned;
              r_nl_op    <= OP_WRITE;
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_hit   <= 1'b1;
            end
          end else begin
            r_misses   <= sat_inc(r_misses);
            r_victim   <= w_victim;
            r_nl_valid <= 1'b1;
            if (w_victim_dirty) begin
              r_state   <= S_WB_REQ;
              r_nl_addr <= w_victim_addr;
              r_nl_op   <= OP_WRITE;
            end else begin
              r_state   <= S_FILL_REQ;
              r_nl_addr <= w_aligned;
              r_nl_op   <= OP_READ;
            end
          end
        end
        S_WB_REQ: begin
          if (bus.nl_ready) begin
            r_wbs     <= sat_inc(r_wbs);
            r_state   <= S_FILL_REQ;
            r_nl_addr <= w_aligned;
            r_nl_op   <= OP_READ;
          end
        end
        S_FILL_REQ: begin
          if (bus.nl_ready) begin
            if (w_is_write && (r_wp == WP_WT)) begin
              r_state <= S_WT_REQ;
              r_nl_op <= OP_WRITE;
            end else begin
              r_state     <= S_RESP;
              r_nl_valid  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_hit   <= 1'b0;
            end
          end
        end
        S_WT_REQ: begin
          if (bus.nl_ready) begin
            r_state     <= S_RESP;
            r_nl_valid  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= r_hit;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_hit   <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_level.sv
// Bench for cache_level: directed scenarios plus randomized traffic checked
// against a timestamp/queue reference model. Two instances share stimulus;
// the second uses 4-bit counters to exercise saturation.
module tb_cache_level;

  localparam logic [7:0] RD = 8'h52;
  localparam logic [7:0] WR = 8'h57;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tb_wp = 1'b0, tb_rp = 1'b0;
  logic        tb_req_valid = 1'b0;
  logic [47:0] tb_req_addr = '0;
  logic [7:0]  tb_req_op = '0;
  logic        tb_nl_ready = 1'b1;

  logic [11:0] m_reads, m_writes, m_hits, m_misses, m_wbs;
  logic [3:0]  s_reads, s_writes, s_hits, s_misses, s_wbs;

  always #5 clk = ~clk;

  cache_level_if #(.ADDR_W(48)) if_m ();
  cache_level_if #(.ADDR_W(48)) if_s ();

  assign if_m.req_valid = tb_req_valid;
  assign if_m.req_addr  = tb_req_addr;
  assign if_m.req_op    = tb_req_op;
  assign if_m.nl_ready  = tb_nl_ready;
  assign if_s.req_valid = tb_req_valid;
  assign if_s.req_addr  = tb_req_addr;
  assign if_s.req_op    = tb_req_op;
  assign if_s.nl_ready  = tb_nl_ready;

  cache_level #(.ADDR_W(48), .NUM_SETS(64), .ASSOC(4), .BLOCK_BYTES(64), .CNT_W(12)) u_dut (
    .clk(clk), .reset(reset), .write_policy(tb_wp), .replace_policy(tb_rp), .bus(if_m),
    .reads(m_reads), .writes(m_writes), .hits(m_hits), .misses(m_misses), .writebacks(m_wbs)
  );

  cache_level #(.ADDR_W(48), .NUM_SETS(64), .ASSOC(4), .BLOCK_BYTES(64), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .write_policy(tb_wp), .replace_policy(tb_rp), .bus(if_s),
    .reads(s_reads), .writes(s_writes), .hits(s_hits), .misses(s_misses), .writebacks(s_wbs)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [35:0] md_tag   [64][4];
  bit          md_valid [64][4];
  bit          md_dirty [64][4];
  int          md_stamp [64][4];
  int          md_ptr   [64];
  int          now;
  int          c_reads, c_writes, c_hits, c_misses, c_wbs;
  logic [55:0] exp_q[$];
  logic [55:0] got_q[$];
  bit          exp_hit, last_hit;
  int          last_lat;

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      md_ptr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        md_valid[s][w] = 0; md_dirty[s][w] = 0; md_stamp[s][w] = 0; md_tag[s][w] = '0;
      end
    end
    now = 0; c_reads = 0; c_writes = 0; c_hits = 0; c_misses = 0; c_wbs = 0;
  endtask

  task automatic model_req(input logic [47:0] a, input logic [7:0] op, input bit wb, input bit lru);
    logic [5:0]  s;
    logic [35:0] t;
    logic [47:0] blk;
    bit          isw;
    int          way, v;
    exp_q.delete();
    exp_hit = 0;
    if (op != RD && op != WR) return;
    s = a[11:6]; t = a[47:12]; blk = {a[47:6], 6'b0}; isw = (op == WR);
    if (isw) c_writes++; else c_reads++;
    now++;
    way = -1;
    for (int w = 0; w < 4; w++) if (md_valid[s][w] && md_tag[s][w] == t) way = w;
    if (way >= 0) begin
      exp_hit = 1; c_hits++;
      md_stamp[s][way] = now;
      if (isw) begin
        if (wb) md_dirty[s][way] = 1;
        else    exp_q.push_back({blk, WR});
      end
    end else begin
      c_misses++;
      v = -1;
      for (int w = 0; w < 4; w++) if (!md_valid[s][w] && v < 0) v = w;
      if (v < 0) begin
        if (lru) begin
          v = 0;
          for (int w = 1; w < 4; w++) if (md_stamp[s][w] < md_stamp[s][v]) v = w;
        end else v = md_ptr[s];
      end
      if (md_valid[s][v] && md_dirty[s][v]) begin
        exp_q.push_back({md_tag[s][v], s, 6'b0, WR});
        c_wbs++;
      end
      exp_q.push_back({blk, RD});
      md_tag[s][v] = t; md_valid[s][v] = 1; md_dirty[s][v] = isw && wb; md_stamp[s][v] = now;
      md_ptr[s] = (md_ptr[s] + 1) % 4;
      if (isw && !wb) exp_q.push_back({blk, WR});
    end
  endtask

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_reads"},  m_reads,  sat(c_reads, 4095));
    chk({tag, "_writes"}, m_writes, sat(c_writes, 4095));
    chk({tag, "_hits"},   m_hits,   sat(c_hits, 4095));
    chk({tag, "_misses"}, m_misses, sat(c_misses, 4095));
    chk({tag, "_wbs"},    m_wbs,    sat(c_wbs, 4095));
    chk({tag, "_s_reads"},  s_reads,  sat(c_reads, 15));
    chk({tag, "_s_writes"}, s_writes, sat(c_writes, 15));
    chk({tag, "_s_hits"},   s_hits,   sat(c_hits, 15));
    chk({tag, "_s_misses"}, s_misses, sat(c_misses, 15));
    chk({tag, "_s_wbs"},    s_wbs,    sat(c_wbs, 15));
  endtask

  // ---------------- DUT driver ----------------
  task automatic run_dut(input logic [47:0] a, input logic [7:0] op, input bit wb, input bit lru,
                         input bit stall);
    int          n;
    bit          done, held;
    logic [55:0] held_v;
    got_q.delete();
    n = 0;
    while (if_m.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", if_m.req_ready, 1);
    tb_req_valid = 1'b1; tb_req_addr = a; tb_req_op = op; tb_wp = wb; tb_rp = lru;
    tb_nl_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    // scramble inputs after accept: only the accepted values may matter
    tb_req_valid = 1'b0; tb_wp = 1'($urandom); tb_rp = 1'($urandom);
    tb_req_addr = {16'($urandom), 32'($urandom)}; tb_req_op = 8'($urandom);
    last_lat = 1; done = 0; held = 0; held_v = '0; last_hit = 0;
    while (!done && last_lat < 200) begin
      if (if_m.rsp_valid === 1'b1) begin
        last_hit = if_m.rsp_hit;
        done = 1;
      end else begin
        if (held) chk("nl_hold_stable", {if_m.nl_valid, if_m.nl_addr, if_m.nl_op}, {1'b1, held_v});
        tb_nl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (if_m.nl_valid === 1'b1 && tb_nl_ready) begin
          got_q.push_back({if_m.nl_addr, if_m.nl_op});
          held = 0;
        end else if (if_m.nl_valid === 1'b1) begin
          held = 1; held_v = {if_m.nl_addr, if_m.nl_op};
        end else held = 0;
        @(negedge clk);
        last_lat++;
      end
    end
    if (!done) chk("rsp_timeout", 0, 1);
    tb_nl_ready = 1'b1;
    @(negedge clk);
    chk("rsp_pulse_one_cycle", if_m.rsp_valid, 0);
  endtask

  task automatic step(input logic [47:0] a, input logic [7:0] op, input bit wb, input bit lru,
                      input bit stall);
    bit legal;
    legal = (op == RD) || (op == WR);
    model_req(a, op, wb, lru);
    run_dut(a, op, wb, lru, stall);
    chk($sformatf("hit@%h", a), last_hit, exp_hit);
    chk($sformatf("nl_count@%h", a), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("nl_xfer%0d@%h", i, a), got_q[i], exp_q[i]);
    if (!legal)                                   chk("lat_illegal", last_lat, 1);
    else if (!stall && exp_hit && exp_q.size() == 0) chk("lat_hit", last_lat, 2);
    else chk("lat_min", (last_lat >= 2 + exp_q.size()), 1);
    chk_counters("cnt");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tb_req_valid = 1'b0; tb_nl_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [55:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '0;
  endfunction

  logic [47:0] seq [6];
  logic [55:0] held_nl;
  int          n;

  initial begin
    seq[0] = 48'h0; seq[1] = 48'h1000; seq[2] = 48'h2000;
    seq[3] = 48'h3000; seq[4] = 48'h0; seq[5] = 48'h4000;

    // reset state
    do_reset();
    chk("rst_req_ready", if_m.req_ready, 1);
    chk("rst_rsp_valid", if_m.rsp_valid, 0);
    chk("rst_rsp_hit",   if_m.rsp_hit, 0);
    chk("rst_nl_valid",  if_m.nl_valid, 0);
    chk("rst_nl_addr",   if_m.nl_addr, 0);
    chk("rst_nl_op",     if_m.nl_op, 0);
    chk_counters("rst");

    // 1: miss then hit in same block
    step(48'h7fff493822b8, RD, 0, 1, 0);
    chk("t1_fill_addr", got_at(0), {48'h7fff49382280, RD});
    step(48'h7fff493822b0, RD, 0, 1, 0);
    chk("t1_hit", last_hit, 1);
    chk("t1_reads", m_reads, 2);
    chk("t1_hits", m_hits, 1);
    chk("t1_misses", m_misses, 1);

    // 2: LRU evicts 0x1000, FIFO evicts 0x0
    do_reset();
    for (int i = 0; i < 6; i++) step(seq[i], RD, 0, 1, 0);
    step(48'h0, RD, 0, 1, 0);    chk("t2_lru_0_hit", last_hit, 1);
    step(48'h1000, RD, 0, 1, 0); chk("t2_lru_1000_miss", last_hit, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(seq[i], RD, 0, 0, 0);
    step(48'h0, RD, 0, 0, 0);    chk("t2_fifo_0_miss", last_hit, 0);

    // 3: write-back eviction of dirty 0x0
    do_reset();
    for (int i = 0; i < 4; i++) step(seq[i], WR, 1, 1, 0);
    step(48'h4000, RD, 1, 1, 0);
    chk("t3_wb_addr", got_at(0), {48'h0, WR});
    chk("t3_fill_addr", got_at(1), {48'h4000, RD});
    chk("t3_writebacks", m_wbs, 1);

    // 4: write-through
    do_reset();
    step(48'h40, WR, 0, 1, 0);
    chk("t4_fill", got_at(0), {48'h40, RD});
    chk("t4_wt", got_at(1), {48'h40, WR});
    chk("t4_miss", last_hit, 0);
    step(48'h40, WR, 0, 1, 0);
    chk("t4_hit", last_hit, 1);
    chk("t4_wt_only_n", got_q.size(), 1);
    chk("t4_wt_only", got_at(0), {48'h40, WR});
    chk("t4_writebacks", m_wbs, 0);

    // 5: stalled fill, then reset mid-operation
    do_reset();
    tb_req_valid = 1'b1; tb_req_addr = 48'h100; tb_req_op = RD; tb_nl_ready = 1'b0;
    @(negedge clk);
    tb_req_valid = 1'b0;
    n = 0;
    while (if_m.nl_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("t5_nl_valid_seen", if_m.nl_valid, 1);
    held_nl = {if_m.nl_addr, if_m.nl_op};
    chk("t5_nl_fill", held_nl, {48'h100, RD});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_stall_valid", if_m.nl_valid, 1);
      chk("t5_stall_stable", {if_m.nl_addr, if_m.nl_op}, held_nl);
      chk("t5_stall_req_ready", if_m.req_ready, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; tb_nl_ready = 1'b1;
    model_clear();
    chk("t5_rst_nl_valid", if_m.nl_valid, 0);
    chk("t5_rst_req_ready", if_m.req_ready, 1);
    chk_counters("t5_rst");
    step(48'h100, RD, 0, 1, 0);
    chk("t5_reread_miss", last_hit, 0);

    // 6: counter saturation and illegal op
    do_reset();
    for (int i = 0; i < 20; i++) step(48'h80, RD, 0, 1, 0);
    chk("t6_s_reads", s_reads, 15);
    chk("t6_s_hits", s_hits, 15);
    chk("t6_s_misses", s_misses, 1);
    step(48'h80, 8'h00, 0, 1, 0);
    chk("t6_illegal_hit", last_hit, 0);
    chk("t6_illegal_nreads", m_reads, 20);

    // randomized traffic: few tags over few sets to force evictions
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [47:0] a;
      logic [7:0]  op;
      int          r;
      a = {36'($urandom_range(0, 5)) * 36'h0_1234_567, 6'($urandom_range(0, 2)), 6'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0) begin
        op = 8'($urandom);
        if (op == RD || op == WR) op = 8'hFF;
      end else op = (r < 6) ? RD : WR;
      step(a, op, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
